// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared HI/LO unit types: operation encoding, FSM states, width.
//               Optional build macro: MULDIV_FAST_MULT_EN (single-cycle multiply).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    // Decoder-side selector for MFHI/MFLO reads.
    typedef enum logic [1:0] {
        HILO_NONE = 2'd0,
        HILO_HI   = 2'd1,
        HILO_LO   = 2'd2
    } hilo_read_t;

    function automatic logic is_long_op(input muldiv_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_muldiv_op(input muldiv_op_t op);
        return is_long_op(op) || (op == MTHI) || (op == MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_core
// Description : 64-bit accumulator with one-bit-per-cycle shift-add multiply
//               and restoring divide step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core
    import muldiv_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                div_mode,
    input  logic [DATA_W-1:0]   load_operand,
    input  logic [2*DATA_W-1:0] load_acc,
    output logic [2*DATA_W-1:0] acc
);

    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_operand;
    logic                r_div_mode;

    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W:0]   w_shift;
    logic [DATA_W+1:0]   w_diff;
    logic                w_neg;
    logic [2*DATA_W-1:0] w_next;

    // Multiply: {hi,lo} holds {partial, multiplier}. Divide: {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_operand} : '0);
        w_shift   = {r_acc, 1'b0};
        w_diff    = {1'b0, w_shift[2*DATA_W:DATA_W]} - {2'b00, r_operand};
        w_neg     = |w_diff[DATA_W+1:DATA_W];
        if (r_div_mode) begin
            w_next = w_neg ? w_shift[2*DATA_W-1:0]
                           : {w_diff[DATA_W-1:0], w_shift[DATA_W-1:1], 1'b1};
        end else begin
            w_next = {w_mul_sum, r_acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_operand  <= '0;
            r_div_mode <= 1'b0;
        end else if (load) begin
            r_acc      <= load_acc;
            r_operand  <= load_operand;
            r_div_mode <= div_mode;
        end else if (step) begin
            r_acc      <= w_next;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : HI/LO multiply/divide sequencer with pipeline stall/flush.
//               Build macro MULDIV_FAST_MULT_EN selects single-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              read_req,
    input  logic              flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              stall,
    output logic              done
);

    muldiv_state_t       r_state;
    logic [4:0]          r_count;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_opa;
    logic                r_busy;
    logic                r_done;
    logic                r_is_div;
    logic                r_div_zero;
    logic                r_neg_lo;
    logic                r_neg_hi;

    logic                w_is_div;
    logic                w_is_signed;
    logic                w_sa;
    logic                w_sb;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic                w_accept;
    logic                w_launch;
    logic                w_step;
    logic                w_stall;
    logic [DATA_W-1:0]   w_load_operand;
    logic [2*DATA_W-1:0] w_load_acc;
    logic [2*DATA_W-1:0] w_acc;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    always_comb begin
        w_is_div       = (op == DIV) || (op == DIVU);
        w_is_signed    = (op == MULT) || (op == DIV);
        w_sa           = w_is_signed & opa[DATA_W-1];
        w_sb           = w_is_signed & opb[DATA_W-1];
        w_mag_a        = w_sa ? -opa : opa;
        w_mag_b        = w_sb ? -opb : opb;
        w_accept       = (r_state == IDLE) && start && !flush;
        w_launch       = w_accept && is_long_op(op);
        w_step         = (r_state == RUN);
        w_load_operand = w_is_div ? w_mag_b : w_mag_a;
`ifdef MULDIV_FAST_MULT_EN
        w_load_acc     = w_is_div ? {{DATA_W{1'b0}}, w_mag_a}
                                  : {{DATA_W{1'b0}}, w_mag_a} * {{DATA_W{1'b0}}, w_mag_b};
`else
        w_load_acc     = {{DATA_W{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
`endif
        w_prod         = r_neg_lo ? -w_acc : w_acc;
        w_quo          = r_neg_lo ? -w_acc[DATA_W-1:0] : w_acc[DATA_W-1:0];
        w_rem          = r_neg_hi ? -w_acc[2*DATA_W-1:DATA_W] : w_acc[2*DATA_W-1:DATA_W];
        // Held in reset so a requester never sees a stall while the unit is down.
        w_stall        = rst_n & ((r_busy & (start | read_req)) |
                                  (!r_busy & start & read_req & is_muldiv_op(op)));
    end

    muldiv_iter_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (w_launch),
        .step         (w_step),
        .div_mode     (w_is_div),
        .load_operand (w_load_operand),
        .load_acc     (w_load_acc),
        .acc          (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= 5'd0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opa      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && (op == MTHI)) begin
                        r_hi <= opa;
                    end else if (w_accept && (op == MTLO)) begin
                        r_lo <= opa;
                    end else if (w_launch) begin
                        r_count    <= 5'd0;
                        r_opa      <= opa;
                        r_is_div   <= w_is_div;
                        r_div_zero <= w_is_div && (opb == '0);
                        r_neg_lo   <= w_sa ^ w_sb;
                        r_neg_hi   <= w_sa;
                        r_busy     <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                        r_state    <= w_is_div ? RUN : FIXUP;
`else
                        r_state    <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_is_div && r_div_zero) begin
                            r_hi <= r_opa;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign done  = r_done;
    assign stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer against an
//               arithmetic reference model (honours MULDIV_FAST_MULT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        read_req;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .read_req (read_req),
        .flush    (flush),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    // Architectural result of one operation, computed with plain arithmetic.
    task automatic ref_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MULT:  {m_hi, m_lo} = sa * sb;
            MULTU: {m_hi, m_lo} = ua * ub;
            DIV, DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (o == DIV) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MTHI:    m_hi = a;
            MTLO:    m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_long(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        int n;
        int lat;
        lat = (o == DIV || o == DIVU) ? DIV_LAT : MUL_LAT;
        ref_op(o, a, b);
        op = o; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
        chk({tag, ".busy_end"}, 64'(busy), 64'd0);
        tick();
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_mt(input muldiv_op_t o, input logic [31:0] a, input string tag);
        ref_op(o, a, 32'd0);
        op = o; opa = a; opb = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          n;
        int          cnt;
        muldiv_op_t  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset with a request pending: nothing may leak through.
        rst_n = 1'b0; start = 1'b1; read_req = 1'b1; flush = 1'b0;
        op = MULT; opa = 32'd9; opb = 32'd9;
        tick(); tick();
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.stall", 64'(stall), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        rst_n = 1'b1; start = 1'b0; read_req = 1'b0;
        tick();

        run_long(MULT, -32'sd3, 32'd7, "mult_m3x7");
        run_long(DIV, -32'sd7, 32'd2, "div_m7d2");
        run_long(DIVU, 32'd7, 32'd2, "divu_7d2");
        run_long(DIVU, 32'd5, 32'd0, "divu_by0");
        run_long(DIV, -32'sd5, 32'd0, "div_by0");
        run_long(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_long(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");

        // Stall while a read waits on an in-flight multiply.
        ref_op(MULT, 32'd1000, -32'sd9);
        op = MULT; opa = 32'd1000; opb = -32'sd9; start = 1'b1;
        tick();
        start = 1'b0; read_req = 1'b1;
        n = 0; cnt = 0;
        while (!done && n < 40) begin
            if (stall) cnt++;
            tick();
            n++;
        end
        chk("stall.cycles", 64'(cnt), 64'(MUL_LAT));
        chk("stall.at_done", 64'(stall), 64'd0);
        chk("stall.done", 64'(done), 64'd1);
        chk("stall.hi", 64'(hi), 64'(m_hi));
        chk("stall.lo", 64'(lo), 64'(m_lo));
        read_req = 1'b0;
        tick();

        // Idle start plus read in the same cycle holds the pipe for one cycle.
        op = MTHI; opa = 32'hCAFE; start = 1'b1; read_req = 1'b1;
        #1;
        chk("idle_stall.on", 64'(stall), 64'd1);
        ref_op(MTHI, 32'hCAFE, 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("idle_stall.off", 64'(stall), 64'd0);
        chk("idle_stall.hi", 64'(hi), 64'(m_hi));
        read_req = 1'b0;

        // Flush at RUN cycle 10, with a start ignored while busy.
        run_mt(MTHI, 32'h11, "mthi_11");
        run_mt(MTLO, 32'h22, "mtlo_22");
        op = DIV; opa = 32'd100; opb = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = MTLO; opa = 32'hDEAD; start = 1'b1;
        #1;
        chk("busy_start.stall", 64'(stall), 64'd1);
        tick();
        start = 1'b0;
        chk("busy_start.lo", 64'(lo), 64'h22);
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_run.busy", 64'(busy), 64'd0);
        chk("flush_run.hi", 64'(hi), 64'h11);
        chk("flush_run.lo", 64'(lo), 64'h22);
        cnt = 0;
        repeat (40) begin
            if (done) cnt++;
            tick();
        end
        chk("flush_run.no_done", 64'(cnt), 64'd0);
        chk("flush_run.lo_late", 64'(lo), 64'h22);

        // Flush coinciding with completion in FIXUP wins.
        op = DIVU; opa = 32'd50; opb = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        chk("flush_fix.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fix.done", 64'(done), 64'd0);
        chk("flush_fix.busy", 64'(busy), 64'd0);
        chk("flush_fix.hi", 64'(hi), 64'(m_hi));
        chk("flush_fix.lo", 64'(lo), 64'(m_lo));

        // Flush in IDLE discards a same-cycle start.
        op = MTLO; opa = 32'h5555; start = 1'b1; flush = 1'b1;
        tick();
        op = DIVU;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_idle.lo", 64'(lo), 64'(m_lo));
        chk("flush_idle.busy", 64'(busy), 64'd0);

        // Randomised operations against the model.
        for (int i = 0; i < 30; i++) begin
            ro = muldiv_op_t'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 9);
                2: ra = 32'h8000_0000;
                3: rb = -32'sd1;
                default: ;
            endcase
            if (ro == MTHI || ro == MTLO) run_mt(ro, ra, "rand_mt");
            else run_long(ro, ra, rb, "rand_long");
        end

        // Asynchronous reset mid-RUN, then a one-cycle MTLO.
        run_mt(MTHI, 32'h77, "pre_reset");
        op = DIVU; opa = 32'd100; opb = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; read_req = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.hi", 64'(hi), 64'd0);
        chk("async_rst.lo", 64'(lo), 64'd0);
        chk("async_rst.busy", 64'(busy), 64'd0);
        chk("async_rst.stall", 64'(stall), 64'd0);
        chk("async_rst.done", 64'(done), 64'd0);
        m_hi = '0; m_lo = '0;
        tick();
        rst_n = 1'b1; read_req = 1'b0;
        tick();
        run_mt(MTLO, 32'h1234, "mtlo_after_rst");
        cnt = 0;
        repeat (40) begin
            if (done) cnt++;
            tick();
        end
        chk("after_rst.no_done", 64'(cnt), 64'd0);
        chk("after_rst.hi", 64'(hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL declare parameter: none; widths fixed by shared package (DATA_W=32).
REQ-002 SHALL have port: clk  input  1  single clock for all state; rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  EX-stage request to launch op this cycle.
REQ-005 SHALL have port: op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port: opa, opb  input  32 each  rs / rt operand values.
REQ-007 SHALL have port: read_req  input  1  ID-stage MFHI/MFLO needs HI/LO.
REQ-008 SHALL have port: flush  input  1  abort the in-flight op (exception/redirect).
REQ-009 SHALL have port: hi, lo  output  32 each  architectural HI/LO registers.
REQ-010 SHALL have port: busy, stall, done  output  1 each  op in flight; pipeline hold; completion pulse.

Function
REQ-011 SHALL use FSM states IDLE, RUN, FIXUP; start accepted only in IDLE.
REQ-012 SHALL, on accepted MULT/MULTU/DIV/DIVU at edge N: latch operands (signed ops on magnitudes, record result signs), go to RUN, cycle counter = 0.
REQ-013 SHALL iterate one bit per cycle in RUN (shift-add multiply, restoring divide); after 32 RUN cycles go to FIXUP.
REQ-014 SHALL in FIXUP apply sign correction (product negate; quotient sign = sa^sb, remainder sign = sa), write {HI,LO} at edge N+33, return to IDLE.
REQ-015 SHALL write product as HI=upper 32, LO=lower 32; divide as LO=quotient, HI=remainder.
REQ-016 SHALL, on divide with opb==0, skip sign fixup and write LO=32'hFFFF_FFFF, HI=opa (signed and unsigned alike).
REQ-017 SHALL pulse done=1 for exactly the one cycle after the HI/LO write edge.
REQ-018 SHALL drive busy=1 whenever state != IDLE.
REQ-019 SHALL execute MTHI/MTLO in IDLE in one cycle: HI (or LO) = opa at the accepting edge; no busy, no done.
REQ-020 SHALL drive stall = busy & (start | read_req) | (start & read_req & op is MULT/MULTU/DIV/DIVU/MTHI/MTLO in IDLE).
REQ-021 SHALL ignore start while busy (requester is held by stall and re-presents).
REQ-022 SHALL, on flush in RUN or FIXUP, return to IDLE next edge with HI/LO unchanged and no done; flush in IDLE discards a same-cycle start.
REQ-023 SHALL give flush priority over completion when both coincide in FIXUP.

Reset
REQ-024 SHALL on rst_n low force state=IDLE, counter=0, hi=0, lo=0, busy=0, stall=0, done=0, independent of clk.
REQ-025 SHALL abandon any in-flight op on reset with no HI/LO write.

Configuration
REQ-026 SHALL support macro MULDIV_FAST_MULT_EN: defined -> MULT/MULTU go IDLE->FIXUP directly using a single-cycle 32x32 multiply, HI/LO written at edge N+1; undefined -> iterative 33-cycle path of REQ-013/014. Divide is iterative in both cases.

Structure
REQ-027 SHALL place muldiv_op_t, muldiv_state_t and DATA_W in the shared selector/signals package alongside decoder control types.
REQ-028 SHALL instantiate one sub-module, muldiv_iter_core, holding the 64-bit accumulator/remainder and one-bit-per-cycle step logic; FSM, counter, sign handling and HI/LO stay in muldiv_sequencer.

Verification
REQ-029 SHALL cover: MULT opa=-3, opb=7 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB at edge N+33 (N+1 with fast macro); done one cycle.
REQ-030 SHALL cover: DIV opa=-7, opb=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 SHALL cover: DIVU opa=5, opb=0 -> LO=32'hFFFF_FFFF, HI=5, no sign fixup.
REQ-032 SHALL cover: read_req asserted cycle after MULT start -> stall=1 for 33 cycles, drops the cycle done=1.
REQ-033 SHALL cover: flush at RUN cycle 10 of DIV with prior HI=0x11, LO=0x22 -> IDLE next edge, HI/LO unchanged, done never asserted.
REQ-034 SHALL cover: rst_n low mid-RUN -> all outputs 0 asynchronously; MTLO opa=0x1234 after release -> LO=0x1234 one edge later.
